// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, bubble encoding, major opcodes and
// the fetch-stage state type.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StDrop
    } if_state_t;

    // Instruction fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: flush > load > hold > drain; flush and drain
// insert a bubble but leave the PC untouched.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            hold,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_WORD;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (!hold) begin
            valid <= 1'b0;
            instr <= NOP_WORD;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, branch redirect with
// late-response dropping, and a one-entry skid buffer for decode back-pressure.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [ILEN-1:0] ifid_instr,
    output logic [6:0]      ifid_opcode
);

    localparam logic [XLEN-1:0] RESET_PC_AL = align4(RESET_PC);

    if_state_t       state;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] buf_instr;
    logic            buf_valid;

    logic            can_load;
    logic            ifid_load;
    logic [ILEN-1:0] load_instr;
    logic [XLEN-1:0] target;

    assign target   = align4(branch_target);
    assign can_load = !stall || !ifid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pc        <= RESET_PC_AL;
            buf_instr <= NOP_INSTR;
            buf_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: state <= StIssue;
                StIssue: begin
                    if (branch_taken) begin
                        pc    <= target;
                        state <= StDrop;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (branch_taken) begin
                        // A response arriving with the redirect is stale; drop it here,
                        // otherwise wait for it in StDrop.
                        pc    <= target;
                        state <= imem_rvalid ? StIssue : StDrop;
                    end else if (imem_rvalid) begin
                        if (can_load) begin
                            pc    <= pc + 64'd4;
                            state <= StIssue;
                        end else begin
                            buf_instr <= imem_rdata;
                            buf_valid <= 1'b1;
                            state     <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (branch_taken) begin
                        buf_valid <= 1'b0;
                        pc        <= target;
                        state     <= StIssue;
                    end else if (!stall) begin
                        buf_valid <= 1'b0;
                        pc        <= pc + 64'd4;
                        state     <= StIssue;
                    end
                end
                StDrop: begin
                    if (branch_taken) begin
                        pc <= target;
                    end
                    if (imem_rvalid) begin
                        state <= StIssue;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // pc is not advanced until the fetched word actually enters IF/ID.
    assign ifid_load = !branch_taken &&
                       ((state == StWait && imem_rvalid && can_load) ||
                        (state == StHold && buf_valid && !stall));
    assign load_instr = (state == StHold) ? buf_instr : imem_rdata;

    assign imem_req  = (state == StIssue);
    assign imem_addr = pc;

    ifid_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (branch_taken),
        .load       (ifid_load),
        .hold       (stall),
        .load_pc    (pc),
        .load_instr (load_instr),
        .valid      (ifid_valid),
        .pc         (ifid_pc),
        .instr      (ifid_instr)
    );

    assign ifid_opcode = ifid_instr[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then randomized stall/redirect/latency
// traffic checked by a program-order scoreboard against a hashed memory image.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct {
        int          cyc;
        logic [63:0] tgt;
    } redir_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [6:0]  ifid_opcode;

    logic        w_stall = 1'b0;
    logic        w_branch = 1'b0;
    logic [63:0] w_target = '0;
    logic        w_req;
    logic [63:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_ifid_valid;
    logic [63:0] w_ifid_pc;
    logic [31:0] w_ifid_instr;
    logic [6:0]  w_ifid_opcode;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int delivered = 0;

    logic        sb_en = 1'b0;
    redir_t      redir_q[$];
    logic [31:0] mem_over[logic [63:0]];

    int          lat_min = 1;
    int          lat_max = 1;
    logic        inject = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = '0;

    if_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode)
    );

    if_stage #(
        .RESET_PC (WRAP_PC)
    ) u_dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (w_stall),
        .branch_taken  (w_branch),
        .branch_target (w_target),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (w_rdata),
        .ifid_valid    (w_ifid_valid),
        .ifid_pc       (w_ifid_pc),
        .ifid_instr    (w_ifid_instr),
        .ifid_opcode   (w_ifid_opcode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] h;
        if (mem_over.exists(a)) return mem_over[a];
        h = a[31:0] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"},    64'(imem_req),    64'd0);
        chk({tag, "_addr"},   imem_addr,        64'd0);
        chk({tag, "_valid"},  64'(ifid_valid),  64'd0);
        chk({tag, "_pc"},     ifid_pc,          64'd0);
        chk({tag, "_instr"},  64'(ifid_instr),  64'(NOP));
        chk({tag, "_opcode"}, 64'(ifid_opcode), 64'(7'b0010011));
    endtask

    // Memory: one response per request after lat_min..lat_max cycles.
    initial begin
        forever begin
            step();
            imem_rvalid = 1'b0;
            if (inject) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                inject      = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memword(paddr);
                    pend        = 1'b0;
                end
            end
            @(negedge clk);
            if (rst_n && imem_req) begin
                chk("one_outstanding", 64'(pend), 64'd0);
                chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = int'($urandom_range(lat_max, lat_min));
            end
        end
    end

    // Scoreboard: every instruction entering IF/ID must be the next one in program order.
    initial begin
        logic        prev_valid;
        logic        prev_stall;
        logic [63:0] exp_pc;
        logic [31:0] w;
        redir_t      r;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        exp_pc     = '0;
        forever begin
            @(negedge clk);
            if (!sb_en || !rst_n) begin
                prev_valid = 1'b0;
                prev_stall = 1'b0;
                exp_pc     = '0;
            end else begin
                if (ifid_valid && (!prev_valid || !prev_stall)) begin
                    while (redir_q.size() > 0 && redir_q[0].cyc < cyc) begin
                        r      = redir_q.pop_front();
                        exp_pc = r.tgt;
                    end
                    w = memword(exp_pc);
                    chk("sb_pc", ifid_pc, exp_pc);
                    chk("sb_instr", 64'(ifid_instr), 64'(w));
                    chk("sb_opcode", 64'(ifid_opcode), 64'(w[6:0]));
                    exp_pc = exp_pc + 64'd4;
                    delivered++;
                end
                prev_valid = ifid_valid;
                prev_stall = stall;
            end
        end
    end

    initial begin
        redir_t      r;
        logic [63:0] tgt;
        mem_over[64'h0] = 32'h0000_0033;
        mem_over[64'h4] = 32'h0000_3003;

        repeat (2) step();
        @(negedge clk);
        check_reset("rst");
        chk("rst_wrap_addr", w_addr, WRAP_PC);

        step(); rst_n = 1'b1;                                   // cycle 0
        @(negedge clk);
        chk("idle_req", 64'(imem_req), 64'd0);
        step();                                                 // cycle 1
        @(negedge clk);
        chk("first_req", 64'(imem_req), 64'd1);
        chk("first_addr", imem_addr, 64'h0);
        chk("wrap_first_addr", w_addr, WRAP_PC);
        step(); w_rvalid = 1'b1; w_rdata = 32'h0000_0013;       // cycle 2
        @(negedge clk);
        step(); w_rvalid = 1'b0; stall = 1'b1;                  // cycle 3
        @(negedge clk);
        chk("c3_valid", 64'(ifid_valid), 64'd1);
        chk("c3_pc", ifid_pc, 64'h0);
        chk("c3_opcode", 64'(ifid_opcode), 64'(7'b0110011));
        chk("c3_instr", 64'(ifid_instr), 64'h33);
        chk("c3_req", 64'(imem_req), 64'd1);
        chk("c3_addr", imem_addr, 64'h4);
        chk("wrap_next_addr", w_addr, 64'h0);
        chk("wrap_ifid_pc", w_ifid_pc, WRAP_PC);
        step();                                                 // cycle 4: data while stalled
        @(negedge clk);
        step();                                                 // cycle 5
        @(negedge clk);
        chk("hold_no_req", 64'(imem_req), 64'd0);
        chk("hold_ifid_kept", 64'(ifid_instr), 64'h33);
        step(); stall = 1'b0;                                   // cycle 6
        @(negedge clk);
        chk("unhold_no_req", 64'(imem_req), 64'd0);
        step(); lat_min = 3; lat_max = 3;                       // cycle 7
        @(negedge clk);
        chk("buf_valid", 64'(ifid_valid), 64'd1);
        chk("buf_pc", ifid_pc, 64'h4);
        chk("buf_instr", 64'(ifid_instr), 64'h3003);
        chk("buf_next_addr", imem_addr, 64'h8);
        chk("buf_next_req", 64'(imem_req), 64'd1);
        step(); branch_taken = 1'b1; branch_target = 64'h100;   // cycle 8: redirect in WAIT
        @(negedge clk);
        step(); branch_taken = 1'b0;                            // cycle 9
        @(negedge clk);
        chk("flush_valid", 64'(ifid_valid), 64'd0);
        chk("flush_instr", 64'(ifid_instr), 64'(NOP));
        chk("flush_pc_kept", ifid_pc, 64'h4);
        chk("drop_no_req", 64'(imem_req), 64'd0);
        step();                                                 // cycle 10: late response
        @(negedge clk);
        chk("drop_late_no_req", 64'(imem_req), 64'd0);
        step(); lat_min = 1; lat_max = 1;                       // cycle 11
        @(negedge clk);
        chk("redir_addr", imem_addr, 64'h100);
        chk("redir_req", 64'(imem_req), 64'd1);
        chk("late_discarded", 64'(ifid_valid), 64'd0);
        step(); branch_taken = 1'b1; branch_target = 64'h203;   // cycle 12: redirect with rvalid
        @(negedge clk);
        step(); branch_taken = 1'b0; lat_min = 3; lat_max = 3;  // cycle 13
        @(negedge clk);
        chk("redir2_addr", imem_addr, 64'h200);
        chk("redir2_req", 64'(imem_req), 64'd1);
        chk("redir2_discard", 64'(ifid_valid), 64'd0);
        step();                                                 // cycle 14: WAIT
        @(negedge clk);
        step(); rst_n = 1'b0;                                   // cycle 15: reset mid-request
        @(negedge clk);
        step();                                                 // cycle 16: response in reset
        @(negedge clk);
        check_reset("midrst");
        step();                                                 // cycle 17
        @(negedge clk);
        inject = 1'b1;
        step(); rst_n = 1'b1;                                   // cycle 18: response in IDLE
        @(negedge clk);
        check_reset("idle_rvalid");
        step();                                                 // cycle 19
        @(negedge clk);
        chk("post_rst_req", 64'(imem_req), 64'd1);
        chk("post_rst_addr", imem_addr, 64'h0);
        chk("post_rst_valid", 64'(ifid_valid), 64'd0);
        step();
        @(negedge clk);
        chk("post_rst_instr", 64'(ifid_instr), 64'(NOP));

        step(); rst_n = 1'b0; lat_min = 1; lat_max = 3;
        repeat (5) step();
        sb_en = 1'b1;
        step(); rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            stall        = ($urandom_range(99, 0) < 35);
            branch_taken = ($urandom_range(99, 0) < 6);
            if (branch_taken) begin
                case ($urandom_range(2, 0))
                    0:       tgt = {$urandom, $urandom};
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
                    default: tgt = 64'($urandom_range(255, 0));
                endcase
                branch_target = tgt;
                r.cyc = cyc;
                r.tgt = {tgt[63:2], 2'b00};
                redir_q.push_back(r);
            end
        end
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        sb_en        = 1'b0;
        @(negedge clk);
        chk("liveness", 64'(delivered >= 100), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, bubble instruction placed in IF/ID on flush or empty.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  decode stage cannot accept; IF/ID holds.
REQ-006 branch_taken  in  1  redirect request from execute; one-cycle pulse.
REQ-007 branch_target  in  64  redirect address; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  out  1  one-cycle fetch request pulse.
REQ-009 imem_addr  out  64  fetch address, valid while imem_req=1.
REQ-010 imem_rvalid  in  1  instruction memory response valid; earliest one cycle after imem_req.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-012 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-013 ifid_pc  out  64  PC of the IF/ID instruction.
REQ-014 ifid_instr  out  32  IF/ID instruction word.
REQ-015 ifid_opcode  out  7  ifid_instr[6:0], feeds the main control decoder.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, HOLD, DROP; at most one request outstanding.
REQ-017 IDLE: -> ISSUE on first clock edge after rst_n deasserts.
REQ-018 ISSUE: imem_req=1, imem_addr=pc for exactly this cycle; -> WAIT, or -> DROP with pc=branch_target if branch_taken.
REQ-019 can_load = !stall | !ifid_valid.
REQ-020 WAIT, rvalid & branch_taken: data discarded, pc=branch_target, -> ISSUE.
REQ-021 WAIT, branch_taken & !rvalid: pc=branch_target, -> DROP.
REQ-022 WAIT, rvalid & can_load: IF/ID <= {1, pc, rdata}, pc <= pc+4, -> ISSUE.
REQ-023 WAIT, rvalid & !can_load: rdata captured in one-entry buffer, -> HOLD.
REQ-024 HOLD: branch_taken clears buffer, pc=branch_target, -> ISSUE; else !stall loads IF/ID from buffer, pc <= pc+4, -> ISSUE; else stay.
REQ-025 DROP: rvalid discarded, -> ISSUE; branch_taken in DROP updates pc=branch_target, stays DROP unless rvalid also set.
REQ-026 IF/ID priority: branch_taken (flush: valid=0, instr=NOP_INSTR) > load > stall (hold) > drain (valid=0, instr=NOP_INSTR).
REQ-027 ifid_pc unchanged on flush/drain.
REQ-028 PC arithmetic modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
REQ-029 imem_addr[1:0] always 00.
REQ-030 Best-case throughput one instruction per two cycles with one-cycle memory latency.

Reset
REQ-031 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_opcode=7'b0010011, buffer empty.
REQ-032 Reset mid-request: outstanding response is not tracked; imem_rvalid arriving in IDLE is ignored.

Structure
REQ-033 Shared package riscv_pkg holds XLEN=64, ILEN=32, NOP_INSTR, opcode constants (OP_R 0110011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_IMM 0010011) and enum if_state_t.
REQ-034 One sub-module ifid_reg: IF/ID pipeline register with flush/load/hold inputs, reset to NOP_INSTR.

Verification
REQ-035 Reset release, memory latency 1, data 32'h00000033 at 0 -> imem_req at cycle 1 addr 0, ifid_valid=1 pc=0 opcode=0110011 at cycle 3, next req addr 4.
REQ-036 stall=1 with ifid_valid=1 when rvalid data 32'h00003003 arrives -> HOLD, no imem_req; stall drop -> IF/ID loads 32'h00003003, pc+4 issued next cycle.
REQ-037 branch_taken target 64'h100 during WAIT, rvalid 2 cycles later -> IF/ID flushed to NOP_INSTR, late response discarded, next imem_addr=64'h100.
REQ-038 branch_taken target 64'h203 with rvalid same cycle -> data discarded, next imem_addr=64'h200.
REQ-039 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch accepted -> next imem_addr=0.
REQ-040 rst_n asserted in WAIT, rvalid arriving during reset and in IDLE -> ignored; outputs equal REQ-031 values.
